stopwatch_key_ctrl: RTL and testbench
=====================================

# stopwatch_key_ctrl

Converts the two raw stopwatch push-buttons into the control signals for the count chain. It synchronises and debounces a start/stop key and a clear key, and runs an IDLE/RUN/PAUSE state machine from them. It then gates the incoming count-tick stream into a count enable, so ticks reach the counters only while the stopwatch is running. The block sits between the board keys and the tick-gating/counter stage, and provides the run/pause control that the tick gate consumes.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable clk cycles required to accept a key level change (20 ms at 50 MHz). Legal range is 2 or more.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): width of each debounce counter.

Ports:
- clk, input, 1: system clock. All logic is rising-edge.
- sys_rst_n, input, 1: asynchronous, active-low reset.
- key_ss_n, input, 1: raw start/stop key, active-low, asynchronous to clk.
- key_clr_n, input, 1: raw clear key, active-low, asynchronous to clk.
- tick_in, input, 1: count tick pulse stream, synchronous to clk.
- count_en, output, 1: tick_in & run. Combinational from registered run.
- run, output, 1: registered. High only in state RUN.
- clr_pulse, output, 1: registered one-cycle clear strobe for the counters.
- state, output, 2: registered FSM state. IDLE=00, RUN=01, PAUSE=10. Value 11 is illegal.

## Operation
Key path (one identical instance per key):
- Synchroniser: 2-FF synchroniser. Both flops reset to 1. The output is sync.
- Debounce registers: stable (resets to 1) and counter cnt (resets to 0).
- If sync == stable, cnt <= 0.
- Else if cnt == DEBOUNCE_CYCLES-1, then stable <= sync and cnt <= 0.
- Else cnt <= cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable. Any return of sync to stable restarts the count from 0.
- Press event: registered one-cycle pulse (ss_press or clr_press). It is asserted in the cycle after stable goes 1→0.
- A release (stable going 0→1) generates no event. Holding a key generates exactly one event.

State machine (evaluated on each rising edge):
- IDLE:
  - ss_press → RUN.
  - clr_press → stay in IDLE and still emit clr_pulse.
- RUN:
  - ss_press → PAUSE.
  - clr_press → IDLE.
- PAUSE:
  - ss_press → RUN.
  - clr_press → IDLE.
- ss_press and clr_press in the same cycle: clear wins. Next state is IDLE, clr_pulse fires, and the start/stop press is discarded.
- clr_pulse <= clr_press, registered. It is high for exactly one cycle, coincident with the first cycle of the post-clear state.
- run <= (next_state == RUN). So run and state always change on the same edge.
- Illegal state 11 → IDLE on the next edge, with run=0.
- count_en = tick_in & run. Ticks arriving in IDLE or PAUSE are dropped, not buffered.

## Timing
- Reset values:
  - state=00, run=0, clr_pulse=0, count_en=0.
  - Synchroniser flops and stable are 1; cnt is 0.
- Reset is asynchronous on assertion and synchronous in effect on deassertion. The first event is possible no earlier than DEBOUNCE_CYCLES+3 edges after release.
- Key latency: key sampled low at edge k gives:
  - sync low at edge k+1;
  - cnt counts from edge k+2;
  - stable goes low at edge k+DEBOUNCE_CYCLES+1;
  - press pulse is high in the cycle after edge k+DEBOUNCE_CYCLES+2;
  - state, run and clr_pulse update at edge k+DEBOUNCE_CYCLES+3.
- count_en has zero latency from tick_in and one-edge latency from a state change.
- Reset mid-debounce: cnt and stable return to reset values. A key held low through the release of reset is then accepted after a full DEBOUNCE_CYCLES.
- Two keys changing on the same edge are debounced independently and produce simultaneous presses, resolved by the clear-priority rule.

## Test plan
Use DEBOUNCE_CYCLES=8 and tick_in toggling every cycle.
- Reset: assert sys_rst_n=0 mid-run → state=00, run=0, clr_pulse=0, count_en=0 immediately, with no clk edge needed.
- Glitch rejection: key_ss_n low for 7 cycles, then high → state stays 00 and no press event. A 3-low/1-high/8-low pattern gives exactly one press, counted from the last falling edge.
- Start/stop:
  - key_ss_n held low 20 cycles → state 01 and run=1 exactly 11 edges after the first low sample, with count_en == tick_in from then on.
  - Release, then press again → state 10 and count_en=0.
  - A third press → state 01.
- Clear from PAUSE and RUN: key_clr_n press → clr_pulse high for exactly 1 cycle, state 00 on the same edge, run=0. A clear press in IDLE → clr_pulse fires and state stays 00.
- Simultaneous: both keys fall on the same edge in state RUN → next state 00 and clr_pulse=1, with no transition to PAUSE.
- Reset mid-debounce: key_ss_n low, reset pulsed at cnt=5, key kept low → press accepted only 11 edges after reset release.

Source files
------------

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch key front end: synchronises and debounces the start/stop and clear keys,
// runs the IDLE/RUN/PAUSE state machine and gates the tick stream into count_en.
module stopwatch_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       key_ss_n,
    input  logic       key_clr_n,
    input  logic       tick_in,
    output logic       count_en,
    output logic       run,
    output logic       clr_pulse,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] key_raw;
    logic [1:0] press;
    logic       ss_press;
    logic       clr_press;

    assign key_raw   = {key_clr_n, key_ss_n};
    assign ss_press  = press[0];
    assign clr_press = press[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_d_reg;
            logic             press_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    sync1_reg    <= 1'b1;
                    sync2_reg    <= 1'b1;
                    stable_reg   <= 1'b1;
                    stable_d_reg <= 1'b1;
                    press_reg    <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= key_raw[gi];
                    sync2_reg    <= sync1_reg;
                    stable_d_reg <= stable_reg;
                    // Only the 1->0 transition of the debounced level is an event.
                    press_reg    <= stable_d_reg & ~stable_reg;
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        stable_reg <= sync2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    state_t state_reg;
    logic   run_reg;
    logic   clr_pulse_reg;

    // Clear takes priority over a simultaneous start/stop press.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= ST_IDLE;
            run_reg       <= 1'b0;
            clr_pulse_reg <= 1'b0;
        end else begin
            clr_pulse_reg <= clr_press;
            if (clr_press) begin
                state_reg <= ST_IDLE;
                run_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ss_press ? ST_RUN : ST_IDLE;
                        run_reg   <= ss_press;
                    end
                    ST_RUN: begin
                        state_reg <= ss_press ? ST_PAUSE : ST_RUN;
                        run_reg   <= ~ss_press;
                    end
                    ST_PAUSE: begin
                        state_reg <= ss_press ? ST_RUN : ST_PAUSE;
                        run_reg   <= ss_press;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        run_reg   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state     = state_reg;
    assign run       = run_reg;
    assign clr_pulse = clr_pulse_reg;
    assign count_en  = tick_in & run_reg;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Bench for stopwatch_key_ctrl: directed scenarios plus random key activity, checked
// against a run-length key model and a plain start/stop/clear state model.
module tb_stopwatch_key_ctrl;

    localparam int D = 8;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_ss_n = 1'b1;
    logic       key_clr_n = 1'b1;
    logic       tick_in = 1'b0;
    logic       count_en;
    logic       run;
    logic       clr_pulse;
    logic [1:0] state;

    stopwatch_key_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .key_ss_n  (key_ss_n),
        .key_clr_n (key_clr_n),
        .tick_in   (tick_in),
        .count_en  (count_en),
        .run       (run),
        .clr_pulse (clr_pulse),
        .state     (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: accepted key level, length of the current run of samples that
    // disagree with it, and the edges at which accepted presses reach the state machine.
    logic       m_lvl [2];
    int         m_runlen [2];
    int         ecount = 0;
    int         ss_q[$];
    int         clr_q[$];
    logic [1:0] m_state = IDLE;
    logic       m_clr = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lvl[k]    = 1'b1;
            m_runlen[k] = 0;
        end
        ss_q.delete();
        clr_q.delete();
        m_state = IDLE;
        m_clr   = 1'b0;
    endtask

    task automatic model_edge();
        logic ssp;
        logic clrp;
        logic samp [2];
        ecount++;
        if (!sys_rst_n) begin
            model_reset();
            return;
        end
        ssp  = 1'b0;
        clrp = 1'b0;
        while (ss_q.size() > 0 && ss_q[0] <= ecount) begin
            if (ss_q[0] == ecount) ssp = 1'b1;
            void'(ss_q.pop_front());
        end
        while (clr_q.size() > 0 && clr_q[0] <= ecount) begin
            if (clr_q[0] == ecount) clrp = 1'b1;
            void'(clr_q.pop_front());
        end
        m_clr = clrp;
        if (clrp) m_state = IDLE;
        else if (ssp) m_state = (m_state == RUN) ? PAUSE : RUN;
        samp[0] = key_ss_n;
        samp[1] = key_clr_n;
        for (int k = 0; k < 2; k++) begin
            if (samp[k] != m_lvl[k]) m_runlen[k]++;
            else m_runlen[k] = 0;
            if (m_runlen[k] == D) begin
                m_lvl[k]    = samp[k];
                m_runlen[k] = 0;
                // D low samples ending here reach the state machine 4 edges later.
                if (samp[k] == 1'b0) begin
                    if (k == 0) ss_q.push_back(ecount + 4);
                    else clr_q.push_back(ecount + 4);
                end
            end
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, update the model on the rising edge.
    task automatic step(input logic ss, input logic clr, input logic rstn = 1'b1);
        @(negedge clk);
        key_ss_n  = ss;
        key_clr_n = clr;
        sys_rst_n = rstn;
        tick_in   = ~tick_in;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic hold(input logic ss, input logic clr, input int n);
        for (int i = 0; i < n; i++) step(ss, clr);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        total++;
        if ({state, run, clr_pulse, count_en} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_values: got state=%b run=%b clr=%b cen=%b want all 0",
                     state, run, clr_pulse, count_en);
        end
        step(1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 3);
        total++;
        if (state !== IDLE) begin
            bad++;
            $display("FAIL idle_after_release: got state=%b want 00", state);
        end
    endtask

    task automatic test_start_stop();
        int first_run = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1);
            if (first_run == 0 && state == RUN) first_run = i;
            total++;
            if ({state, run, clr_pulse, count_en} !==
                {m_state, m_state == RUN, m_clr, tick_in & (m_state == RUN)}) begin
                bad++;
                $display("FAIL start_model: step %0d got %b%b%b%b want %b%b%b%b", i,
                         state, run, clr_pulse, count_en,
                         m_state, m_state == RUN, m_clr, tick_in & (m_state == RUN));
            end
        end
        // First low sample is step 1 (edge k); RUN must appear at edge k+11.
        total++;
        if (first_run != 12) begin
            bad++;
            $display("FAIL start_latency: got RUN at step %0d want step 12", first_run);
        end
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 12);
        hold(1'b1, 1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            total++;
            if ({state, count_en} !== {PAUSE, 1'b0}) begin
                bad++;
                $display("FAIL pause: got state=%b cen=%b want 10 0", state, count_en);
            end
        end
        hold(1'b1, 1'b1, 5);
        hold(1'b0, 1'b1, 12);
        hold(1'b1, 1'b1, 10);
        total++;
        if ({state, run, count_en} !== {RUN, 1'b1, tick_in}) begin
            bad++;
            $display("FAIL resume: got state=%b run=%b cen=%b want 01 1 %b",
                     state, run, count_en, tick_in);
        end
    endtask

    task automatic test_clear();
        int pulses;
        for (int pass = 0; pass < 3; pass++) begin
            // pass 0 clears from RUN, pass 1 from PAUSE, pass 2 from IDLE
            if (pass == 1) begin
                hold(1'b0, 1'b1, 12);
                hold(1'b1, 1'b1, 10);
                hold(1'b0, 1'b1, 12);
                hold(1'b1, 1'b1, 10);
                total++;
                if (state !== PAUSE) begin
                    bad++;
                    $display("FAIL clear_setup: got state=%b want 10", state);
                end
            end
            pulses = 0;
            for (int i = 0; i < 22; i++) begin
                step(1'b1, (i < 12) ? 1'b0 : 1'b1);
                if (clr_pulse === 1'b1) begin
                    pulses++;
                    total++;
                    if ({state, run} !== {IDLE, 1'b0}) begin
                        bad++;
                        $display("FAIL clear_state: pass %0d got state=%b run=%b want 00 0",
                                 pass, state, run);
                    end
                end
                total++;
                if ({state, run, clr_pulse} !== {m_state, m_state == RUN, m_clr}) begin
                    bad++;
                    $display("FAIL clear_model: pass %0d step %0d got %b%b%b want %b%b%b",
                             pass, i, state, run, clr_pulse, m_state, m_state == RUN, m_clr);
                end
            end
            total++;
            if (pulses != 1) begin
                bad++;
                $display("FAIL clear_pulse_count: pass %0d got %0d want 1", pass, pulses);
            end
        end
    endtask

    task automatic test_glitch();
        hold(1'b0, 1'b1, 7);
        hold(1'b1, 1'b1, 12);
        total++;
        if (state !== IDLE) begin
            bad++;
            $display("FAIL glitch_7: got state=%b want 00", state);
        end
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            total++;
            if (state !== IDLE) begin
                bad++;
                $display("FAIL glitch_early: step %0d got state=%b want 00", i, state);
            end
        end
        hold(1'b0, 1'b1, 4);
        hold(1'b1, 1'b1, 10);
        total++;
        if (state !== RUN) begin
            bad++;
            $display("FAIL glitch_one_press: got state=%b want 01", state);
        end
    endtask

    task automatic test_simultaneous();
        int seen_clr = 0;
        for (int i = 0; i < 22; i++) begin
            step((i < 12) ? 1'b0 : 1'b1, (i < 12) ? 1'b0 : 1'b1);
            if (clr_pulse === 1'b1) seen_clr++;
            total++;
            if (state === PAUSE || state !== m_state) begin
                bad++;
                $display("FAIL simul_state: step %0d got state=%b want %b", i, state, m_state);
            end
        end
        total++;
        if ({seen_clr, state} !== {32'd1, IDLE}) begin
            bad++;
            $display("FAIL simul_clear: got pulses=%0d state=%b want 1 00", seen_clr, state);
        end
    endtask

    task automatic test_async_reset();
        hold(1'b0, 1'b1, 12);
        hold(1'b1, 1'b1, 10);
        #2;
        tick_in = 1'b1;
        #1;
        total++;
        if ({state, count_en} !== {RUN, 1'b1}) begin
            bad++;
            $display("FAIL pre_reset_run: got state=%b cen=%b want 01 1", state, count_en);
        end
        sys_rst_n = 1'b0;
        #1;
        total++;
        if ({state, run, clr_pulse, count_en} !== 5'b00000) begin
            bad++;
            $display("FAIL async_reset: got state=%b run=%b clr=%b cen=%b want all 0",
                     state, run, clr_pulse, count_en);
        end
        model_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 2);
    endtask

    task automatic test_reset_mid_debounce();
        int first_run = 0;
        hold(1'b0, 1'b1, 7);
        #2;
        sys_rst_n = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (first_run == 0 && state == RUN) first_run = i;
            total++;
            if (state !== m_state) begin
                bad++;
                $display("FAIL mid_debounce_model: step %0d got state=%b want %b",
                         i, state, m_state);
            end
        end
        total++;
        if (first_run != 12) begin
            bad++;
            $display("FAIL mid_debounce_latency: got RUN at step %0d want 12", first_run);
        end
        hold(1'b1, 1'b1, 10);
    endtask

    task automatic test_random();
        logic ss;
        logic clr;
        int   len;
        for (int seg = 0; seg < 60; seg++) begin
            ss  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                step(ss, clr);
                total++;
                if ({state, run, clr_pulse, count_en} !==
                    {m_state, m_state == RUN, m_clr, tick_in & (m_state == RUN)}) begin
                    bad++;
                    $display("FAIL random: seg %0d got %b%b%b%b want %b%b%b%b", seg,
                             state, run, clr_pulse, count_en,
                             m_state, m_state == RUN, m_clr, tick_in & (m_state == RUN));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_stop();
        test_clear();
        test_glitch();
        test_simultaneous();
        test_async_reset();
        test_reset_mid_debounce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
